// File: rtl/base_event_coalesce.sv
// Coalesces a raw event strobe into at most one pulse every `gap` cycles, with an event count.
// Define BASE_EVCOAL_FLUSH_EN to add the i_flush early-emission input.
module base_event_coalesce #(
  parameter int unsigned gap    = 16,
  parameter int unsigned cwidth = 8,
  parameter int unsigned tw     = $clog2(gap)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ev,
`ifdef BASE_EVCOAL_FLUSH_EN
  input  logic              i_flush,
`endif
  output logic              o_pulse,
  output logic [cwidth-1:0] o_cnt,
  output logic              o_sat,
  output logic              o_busy
);

  typedef enum logic [0:0] {StIdle, StCool} state_e;

  localparam logic [cwidth-1:0] CntMax  = '1;
  localparam logic [tw-1:0]     TmrLoad = tw'(gap - 1);

  state_e            state_q, state_d;
  logic [cwidth-1:0] pend_q, pend_d;
  logic [cwidth-1:0] cnt_q, cnt_d;
  logic [tw-1:0]     tmr_q, tmr_d;
  logic              sticky_q, sticky_d;
  logic              pulse_q, pulse_d;
  logic              sat_q, sat_d;

  logic              flush;
  logic              decision;
  logic              add_sat;
  logic              nonzero;
  logic [cwidth-1:0] sum;

`ifdef BASE_EVCOAL_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      pend_q   <= '0;
      tmr_q    <= '0;
      sticky_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      tmr_q    <= tmr_d;
      sticky_q <= sticky_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
    end
  end

  always_comb begin
    decision = (state_q == StIdle) ? i_ev : ((tmr_q == '0) || flush);
    add_sat  = (pend_q == CntMax) && i_ev;
    sum      = add_sat ? CntMax : pend_q + cwidth'(i_ev);
    nonzero  = (pend_q != '0) || i_ev;

    state_d  = state_q;
    pend_d   = pend_q;
    tmr_d    = tmr_q;
    sticky_d = sticky_q;
    pulse_d  = 1'b0;
    cnt_d    = cnt_q;
    sat_d    = sat_q;

    if (decision && nonzero) begin
      pulse_d  = 1'b1;
      cnt_d    = sum;
      sat_d    = sticky_q | add_sat;
      pend_d   = '0;
      sticky_d = 1'b0;
      tmr_d    = TmrLoad;
      state_d  = StCool;
    end else if (decision) begin
      // Only reachable from COOL: nothing pending, so fall back to IDLE silently.
      state_d = StIdle;
      tmr_d   = '0;
    end else if (state_q == StCool) begin
      tmr_d = tmr_q - tw'(1);
      if (i_ev) begin
        if (pend_q == CntMax) begin
          sticky_d = 1'b1;
        end else begin
          pend_d = pend_q + cwidth'(1);
        end
      end
    end
  end

  always_comb begin
    o_pulse = pulse_q;
    o_cnt   = cnt_q;
    o_sat   = sat_q;
    o_busy  = (state_q == StCool);
  end

endmodule

// File: tb/tb_base_event_coalesce.sv
// Bench for base_event_coalesce: two instances (gap=4 and gap=16, cwidth=3) share stimulus and
// are compared every cycle against a cycle-indexed event-window model.
module tb_base_event_coalesce;

`ifdef BASE_EVCOAL_FLUSH_EN
  localparam bit FlushEn = 1'b1;
  logic flush = 1'b0;
`else
  localparam bit FlushEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ev = 1'b0;
  logic p4, s4, b4, p16, s16, b16;
  logic [2:0] c4, c16;

  always #5 clk = ~clk;

  base_event_coalesce #(.gap(4), .cwidth(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_ev(ev),
`ifdef BASE_EVCOAL_FLUSH_EN
    .i_flush(flush),
`endif
    .o_pulse(p4), .o_cnt(c4), .o_sat(s4), .o_busy(b4)
  );

  base_event_coalesce #(.gap(16), .cwidth(3)) dut16 (
    .clk(clk), .rst_n(rst_n), .i_ev(ev),
`ifdef BASE_EVCOAL_FLUSH_EN
    .i_flush(flush),
`endif
    .o_pulse(p16), .o_cnt(c16), .o_sat(s16), .o_busy(b16)
  );

  wire [11:0] obs = {p4, c4, s4, b4, p16, c16, s16, b16};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: remember the cycle of the last emitting decision and the raw count since then.
  int gaps[2] = '{4, 16};
  bit have[2];
  int dec[2];
  int acc[2];
  bit ep[2];
  int ec[2];
  bit es[2];
  bit eb[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      have[k] = 0; dec[k] = 0; acc[k] = 0;
      ep[k] = 0; ec[k] = 0; es[k] = 0; eb[k] = 0;
    end
  endfunction

  function automatic void emit(int k, int c, int tot);
    ep[k]   = 1;
    ec[k]   = (tot > 7) ? 7 : tot;
    es[k]   = (tot > 7);
    dec[k]  = c;
    acc[k]  = 0;
    have[k] = 1;
  endfunction

  function automatic void model_step(int k, int c, bit e, bit f);
    bit cool;
    int tot;
    ep[k] = 0;
    cool = have[k] && (c >= dec[k] + 1) && (c <= dec[k] + gaps[k]);
    if (!cool) begin
      if (e) emit(k, c, 1);
    end else if ((c == dec[k] + gaps[k]) || f) begin
      tot = acc[k] + int'(e);
      if (tot > 0) emit(k, c, tot);
      else have[k] = 0;
    end else begin
      acc[k] += int'(e);
    end
    eb[k] = have[k] && (c + 1 >= dec[k] + 1) && (c + 1 <= dec[k] + gaps[k]);
  endfunction

  function automatic logic [11:0] expv();
    return {ep[0], 3'(ec[0]), es[0], eb[0], ep[1], 3'(ec[1]), es[1], eb[1]};
  endfunction

  // Drive one cycle of stimulus; afterwards the sampled outputs belong to cycle `cyc`.
  task automatic tick(input bit e, input bit f);
    ev = e;
`ifdef BASE_EVCOAL_FLUSH_EN
    flush = f;
`endif
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, cyc, e, f);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    ev = 0;
`ifdef BASE_EVCOAL_FLUSH_EN
    flush = 0;
`endif
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL reset_async got=%h want=000", obs);
    end
    do_reset();
    checks++;
    if (obs !== expv()) begin
      errors++; $display("FAIL reset_release got=%h want=%h", obs, expv());
    end
  endtask

  task automatic test_single();
    int npulse = 0;
    do_reset();
    tick(1, 0);
    checks++;
    if ({p4, c4, s4} !== 5'b1_001_0) begin
      errors++; $display("FAIL single_first got=%b want=10010", {p4, c4, s4});
    end
    for (int i = 1; i < 10; i++) begin
      tick(0, 0);
      npulse += int'(p4);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL single_model cyc=%0d got=%h want=%h", cyc, obs, expv());
      end
      checks++;
      if (b4 !== (cyc <= 4)) begin
        errors++; $display("FAIL single_busy cyc=%0d got=%b want=%b", cyc, b4, cyc <= 4);
      end
    end
    checks++;
    if (npulse != 0) begin
      errors++; $display("FAIL single_extra got=%0d want=0", npulse);
    end
  endtask

  task automatic test_burst();
    int pc[$];
    int pv[$];
    do_reset();
    for (int c = 0; c < 40; c++) begin
      tick(c < 12, 0);
      if (p4) begin pc.push_back(cyc); pv.push_back(int'(c4)); end
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL burst_model cyc=%0d got=%h want=%h", cyc, obs, expv());
      end
      if (cyc == 16 || cyc == 17) begin
        checks++;
        if (b4 !== (cyc == 16)) begin
          errors++; $display("FAIL burst_idle cyc=%0d got=%b want=%b", cyc, b4, cyc == 16);
        end
      end
    end
    checks++;
    if (pc.size() != 4 || pc[0] != 1 || pc[1] != 5 || pc[2] != 9 || pc[3] != 13 ||
        pv[0] != 1 || pv[1] != 4 || pv[2] != 4 || pv[3] != 3) begin
      errors++;
      $display("FAIL burst_pulses got_at=%p cnt=%p want_at=1,5,9,13 cnt=1,4,4,3", pc, pv);
    end
  endtask

  task automatic test_saturation();
    int n = 0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      tick(1, 0);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL sat_model cyc=%0d got=%h want=%h", cyc, obs, expv());
      end
      if (p16) begin
        n++;
        if (n <= 2) begin
          checks++;
          if ({cyc, c16, s16} !== ((n == 1) ? {32'd1, 3'd1, 1'b0} : {32'd17, 3'd7, 1'b1})) begin
            errors++;
            $display("FAIL sat_pulse%0d got cyc=%0d cnt=%0d sat=%b", n, cyc, c16, s16);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int npulse = 0;
    do_reset();
    for (int c = 0; c < 3; c++) tick(1, 0);
    ev = 0;
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL midreset_async got=%h want=000", obs);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 12'h000) begin
      errors++; $display("FAIL midreset_hold got=%h want=000", obs);
    end
    rst_n = 1;
    cyc = 0;
    tick(1, 0);
    checks++;
    if ({p4, c4, p16, c16} !== 8'b1001_1001) begin
      errors++; $display("FAIL midreset_first got=%b want=10011001", {p4, c4, p16, c16});
    end
    for (int c = 1; c < 24; c++) begin
      tick(0, 0);
      npulse += int'(p4) + int'(p16);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL midreset_model cyc=%0d got=%h want=%h", cyc, obs, expv());
      end
    end
    checks++;
    if (npulse != 0) begin
      errors++; $display("FAIL midreset_lost got=%0d want=0", npulse);
    end
  endtask

  task automatic test_decision_event();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      tick(c == 0 || c == 4, 0);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL decev_model cyc=%0d got=%h want=%h", cyc, obs, expv());
      end
      if (cyc == 5) begin
        checks++;
        if ({p4, c4} !== 4'b1001) begin
          errors++; $display("FAIL decev_pulse got=%b want=1001", {p4, c4});
        end
      end
      if (cyc == 8 || cyc == 9) begin
        checks++;
        if (b4 !== (cyc == 8)) begin
          errors++; $display("FAIL decev_idle cyc=%0d got=%b want=%b", cyc, b4, cyc == 8);
        end
      end
    end
  endtask

  task automatic test_random();
    int dens = 50;
    do_reset();
    for (int c = 0; c < 700; c++) begin
      if (c % 100 == 0) dens = $urandom_range(5, 95);
      tick(c < 660 && $urandom_range(0, 99) < dens, FlushEn && ($urandom_range(0, 15) == 0));
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL random_model cyc=%0d got=%h want=%h", cyc, obs, expv());
      end
    end
  endtask

`ifdef BASE_EVCOAL_FLUSH_EN
  task automatic test_flush();
    do_reset();
    for (int c = 0; c < 32; c++) begin
      tick(c == 0 || c == 2 || c == 3, c == 5);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL flush_model cyc=%0d got=%h want=%h", cyc, obs, expv());
      end
      if (cyc == 6) begin
        checks++;
        if ({p16, c16} !== 4'b1010) begin
          errors++; $display("FAIL flush_pulse got=%b want=1010", {p16, c16});
        end
      end else if (cyc > 6 && cyc < 22 && p16 !== 1'b0) begin
        errors++; $display("FAIL flush_spacing cyc=%0d got=1 want=0", cyc);
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick(0, 1);
      checks++;
      if ({p4, b4, p16, b16} !== 4'b0000) begin
        errors++; $display("FAIL flush_idle got=%b want=0000", {p4, b4, p16, b16});
      end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_saturation();
    test_reset_mid();
    test_decision_event();
`ifdef BASE_EVCOAL_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
